// File: rtl/router_pkg.sv
// Shared constants and types for the router output-port FIFOs.
package router_pkg;

  localparam int ROUTER_WIDTH      = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int LEN_LSB           = 2;

  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } fifo_word_t;

  // Payload length carried in the upper bits of a header byte.
  function automatic logic [ROUTER_WIDTH-LEN_LSB-1:0] hdr_len(input logic [ROUTER_WIDTH-1:0] b);
    return b[ROUTER_WIDTH-1:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Client/router-side handshake of one output-port FIFO.
// ROUTER_FIFO_ERR_FLAG_EN adds the sticky ovf_err/udf_err flags.
interface router_fifo_if
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH
);
  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             dout_valid;
  logic             pkt_active;
  logic             full;
  logic             empty;
`ifdef ROUTER_FIFO_ERR_FLAG_EN
  logic             ovf_err;
  logic             udf_err;
`endif

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, dout_valid, pkt_active, full, empty
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    , input ovf_err, udf_err
`endif
  );

  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, dout_valid, pkt_active, full, empty
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    , output ovf_err, udf_err
`endif
  );

endinterface

// File: rtl/router_fifo.sv
// Output-port FIFO of the 1x4 router; tags header bytes and tracks packet length on read.
// ROUTER_FIFO_ERR_FLAG_EN enables sticky overflow/underflow flags.
module router_fifo #(
  parameter int WIDTH   = router_pkg::ROUTER_WIDTH,
  parameter int DEPTH   = router_pkg::ROUTER_FIFO_DEPTH,
  parameter int LEN_LSB = router_pkg::LEN_LSB
) (
  input  logic           clk,
  input  logic           rst,
  router_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = WIDTH - LEN_LSB + 1;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] tag;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [WIDTH-1:0] rd_word;
  logic             flush, do_wr, do_rd;

  assign flush   = rst | bus.soft_reset;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  assign bus.empty = (wr_ptr == rd_ptr);
  assign bus.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_wr = bus.write_enb && !bus.full  && !flush;
  assign do_rd = bus.read_enb  && !bus.empty && !flush;

  assign bus.data_out   = data_q;
  assign bus.dout_valid = valid_q;
  assign bus.pkt_active = (count != '0);

  // Data array carries no reset so it maps onto plain storage.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag     <= '0;
      count   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_wr) begin
        tag[wr_ptr[AW-1:0]] <= bus.lfd_state;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      valid_q <= do_rd;
      if (do_rd) begin
        data_q <= rd_word;
        rd_ptr <= rd_ptr + (AW+1)'(1);
        // A header anywhere restarts the count: payload plus parity byte.
        if (tag[rd_ptr[AW-1:0]])
          count <= {1'b0, rd_word[WIDTH-1:LEN_LSB]} + CW'(1);
        else if (count != '0)
          count <= count - CW'(1);
      end
    end
  end

`ifdef ROUTER_FIFO_ERR_FLAG_EN
  logic ovf_q, udf_q;

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.write_enb && bus.full)  ovf_q <= 1'b1;
      if (bus.read_enb  && bus.empty) udf_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = '0;
    bus.read_enb   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    bus.write_enb = 1'b1;
    bus.data_in   = d;
    bus.lfd_state = l;
    step();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] wrap_byte(input int j);
    if (j == 0) return 8'h1C;
    if (j == 9) return 8'h08;
    return 8'h80 + 8'(j);
  endfunction

  task automatic test_reset();
    do_reset();
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", bus.full); end
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid); end
    tests++; if (bus.data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
    tests++; if (bus.pkt_active !== 1'b0) begin fails++; $display("FAIL reset_pkt: got %b want 0", bus.pkt_active); end
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    tests++; if ({bus.ovf_err, bus.udf_err} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", {bus.ovf_err, bus.udf_err}); end
`endif
  endtask

  task automatic test_packet();
    logic [7:0] exp_d [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h4F};
    logic       exp_p [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    wr(8'h0D, 1'b1);
    wr(8'hA1, 1'b0);
    wr(8'hA2, 1'b0);
    wr(8'hA3, 1'b0);
    wr(8'h4F, 1'b0);
    tests++; if (bus.pkt_active !== 1'b0) begin fails++; $display("FAIL pkt_before_read: got %b want 0", bus.pkt_active); end
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (bus.data_out !== exp_d[i] || bus.dout_valid !== 1'b1) begin fails++; $display("FAIL pkt_data[%0d]: got %h/%b want %h/1", i, bus.data_out, bus.dout_valid, exp_d[i]); end
      tests++; if (bus.pkt_active !== exp_p[i]) begin fails++; $display("FAIL pkt_active[%0d]: got %b want %b", i, bus.pkt_active, exp_p[i]); end
    end
    bus.read_enb = 1'b0;
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL pkt_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL full_early[%0d]: got %b want 0", i, bus.full); end
      wr(8'h10 + 8'(i), 1'b0);
    end
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL full_set: got %b want 1", bus.full); end
    wr(8'hFF, 1'b0);
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL full_hold: got %b want 1", bus.full); end
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    tests++; if (bus.ovf_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b want 1", bus.ovf_err); end
`endif
    bus.read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      tests++; if (bus.data_out !== 8'h10 + 8'(i) || bus.dout_valid !== 1'b1) begin fails++; $display("FAIL full_drain[%0d]: got %h/%b want %h/1", i, bus.data_out, bus.dout_valid, 8'h10 + 8'(i)); end
    end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL full_empty: got %b want 1", bus.empty); end
    step();
    tests++; if (bus.dout_valid !== 1'b0 || bus.data_out !== 8'h1F) begin fails++; $display("FAIL full_overread: got %h/%b want 1f/0", bus.data_out, bus.dout_valid); end
    bus.read_enb = 1'b0;
  endtask

  task automatic test_simul();
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 15; i++) wr(8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.write_enb = 1'b1;
      bus.data_in   = 8'h40 + 8'(i);
      bus.read_enb  = 1'b1;
      step();
      tests++; if (bus.data_out !== 8'h20 + 8'(i) || bus.full !== 1'b0) begin fails++; $display("FAIL simul_rw[%0d]: got %h full=%b want %h full=0", i, bus.data_out, bus.full, 8'h20 + 8'(i)); end
    end
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    wr(8'h44, 1'b0);
    tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL simul_full: got %b want 1", bus.full); end
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hEE;
    bus.read_enb  = 1'b1;
    step();
    bus.write_enb = 1'b0;
    tests++; if (bus.data_out !== 8'h24 || bus.dout_valid !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL simul_at_full: got %h/%b full=%b want 24/1 full=0", bus.data_out, bus.dout_valid, bus.full); end
    for (int k = 0; k < 15; k++) begin
      e = (k < 10) ? 8'h25 + 8'(k) : 8'h40 + 8'(k - 10);
      step();
      tests++; if (bus.data_out !== e || bus.dout_valid !== 1'b1) begin fails++; $display("FAIL simul_drain[%0d]: got %h/%b want %h/1", k, bus.data_out, bus.dout_valid, e); end
    end
    bus.read_enb = 1'b0;
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL simul_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_soft_reset();
    do_reset();
    wr(8'h14, 1'b1);
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1'b0);
    bus.read_enb = 1'b1;
    step();
    bus.read_enb = 1'b0;
    tests++; if (bus.pkt_active !== 1'b1 || bus.data_out !== 8'h14) begin fails++; $display("FAIL sr_pre: got %h pkt=%b want 14 pkt=1", bus.data_out, bus.pkt_active); end
    bus.soft_reset = 1'b1;
    step();
    bus.soft_reset = 1'b0;
    tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL sr_flags: got empty=%b full=%b want 1/0", bus.empty, bus.full); end
    tests++; if (bus.pkt_active !== 1'b0 || bus.dout_valid !== 1'b0 || bus.data_out !== 8'h00) begin fails++; $display("FAIL sr_outs: got pkt=%b v=%b d=%h want 0/0/00", bus.pkt_active, bus.dout_valid, bus.data_out); end
    bus.read_enb = 1'b1;
    step();
    bus.read_enb = 1'b0;
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL sr_noread: got %b want 0", bus.dout_valid); end
`ifdef ROUTER_FIFO_ERR_FLAG_EN
    tests++; if (bus.udf_err !== 1'b1) begin fails++; $display("FAIL udf_err: got %b want 1", bus.udf_err); end
`endif
  endtask

  task automatic test_wrap();
    logic ep;
    do_reset();
    bus.read_enb = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      bus.write_enb = (k < 40);
      bus.data_in   = wrap_byte(k);
      bus.lfd_state = (k == 0 || k == 9);
      step();
      if (k == 0) begin
        tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL wrap_first: got %b want 0", bus.dout_valid); end
      end else begin
        ep = ((k - 1) <= 7) || ((k - 1) >= 9 && (k - 1) <= 11);
        tests++; if (bus.data_out !== wrap_byte(k - 1) || bus.dout_valid !== 1'b1) begin fails++; $display("FAIL wrap_data[%0d]: got %h/%b want %h/1", k - 1, bus.data_out, bus.dout_valid, wrap_byte(k - 1)); end
        tests++; if (bus.pkt_active !== ep) begin fails++; $display("FAIL wrap_pkt[%0d]: got %b want %b", k - 1, bus.pkt_active, ep); end
      end
    end
    idle_inputs();
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_empty_rw();
    do_reset();
    bus.read_enb  = 1'b1;
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h55;
    step();
    bus.write_enb = 1'b0;
    tests++; if (bus.dout_valid !== 1'b0 || bus.empty !== 1'b0) begin fails++; $display("FAIL erw_first: got v=%b empty=%b want 0/0", bus.dout_valid, bus.empty); end
    step();
    bus.read_enb = 1'b0;
    tests++; if (bus.data_out !== 8'h55 || bus.dout_valid !== 1'b1 || bus.empty !== 1'b1) begin fails++; $display("FAIL erw_read: got %h/%b empty=%b want 55/1 empty=1", bus.data_out, bus.dout_valid, bus.empty); end
    step();
    tests++; if (bus.dout_valid !== 1'b0) begin fails++; $display("FAIL erw_strobe: got %b want 0", bus.dout_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_packet();
    test_full();
    test_simul();
    test_soft_reset();
    test_wrap();
    test_empty_rw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Output-port FIFO of the 1x4 router, one instance per destination port. It sits directly downstream of the packet register stage and accepts header, payload and parity bytes in write order. It tags each header byte so the read side can track packet boundaries. The read side is drained by the destination client and reports full/empty to the router FSM and synchroniser.

Parameters:
WIDTH, 8, data byte width.
DEPTH, 16, number of entries; power of two, at least 4.
LEN_LSB, 2, LSB of the payload-length field in the header byte; the field spans [WIDTH-1:LEN_LSB].

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
soft_reset  in  1  synchronous flush from the synchroniser timeout; active-high.
write_enb  in  1  write request from the synchroniser for this port.
lfd_state  in  1  high while the FSM loads the header byte; tags the word being written.
data_in  in  WIDTH  byte from the register stage (its dout).
read_enb  in  1  read request from the destination client.
data_out  out  WIDTH  registered read data.
dout_valid  out  1  one-cycle strobe; data_out was updated this cycle.
pkt_active  out  1  high while bytes of the current packet remain to be read.
full  out  1  DEPTH entries stored.
empty  out  1  zero entries stored.

Behaviour:
- Storage: DEPTH words of WIDTH+1 bits. Bit WIDTH is the header tag (the lfd_state value captured at write).
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits.
  - empty = pointers equal.
  - full = MSBs differ and the remaining bits are equal.
  - Both flags are combinational from registered pointers.
- Write: when write_enb && !full, store {lfd_state, data_in} at wr_ptr and increment wr_ptr (wraps naturally). When write_enb && full, drop the write silently and leave the pointer unchanged.
- Read: when read_enb && !empty:
  - data_out <= stored byte; dout_valid <= 1; rd_ptr increments.
  - If the tag is set, count <= header[WIDTH-1:LEN_LSB] + 1 (payload plus parity byte).
  - Otherwise, if count != 0, count decrements.
  - count width is WIDTH-LEN_LSB+1 bits, so no overflow.
- If read_enb && empty: dout_valid <= 0 and data_out holds its value.
- Latency: one cycle from an accepted read to data_out/dout_valid. There is no write-to-read bypass; a byte written in cycle N is readable in cycle N+1.
- pkt_active = (count != 0), registered via count.
  - A header read sets it in the next cycle.
  - It falls in the cycle after the parity byte is read.
- Simultaneous read and write:
  - Both proceed when neither flag blocks them.
  - When full, the read proceeds and the write is dropped, because full is evaluated before the edge.
  - When empty, the write proceeds and the read is blocked.
- Header tag on a non-first byte (lfd_state asserted mid-packet): the tag reloads count, so the latest header wins.
- rst: pointers, count, data_out, dout_valid and all tags go to 0; empty=1, full=0. Memory contents need not be cleared.
- soft_reset: identical effect to rst, for this port only. rst has priority.
- Writes or reads coinciding with rst or soft_reset are discarded.

Optional Feature:
ROUTER_FIFO_ERR_FLAG_EN
- Defined: adds outputs ovf_err and udf_err (1 bit each, sticky).
  - ovf_err sets on write_enb && full.
  - udf_err sets on read_enb && empty.
  - Both clear only on rst or soft_reset; reset value 0.
- Undefined: these ports and their logic do not exist, and overflow/underflow attempts are ignored as described above.

Decomposition:
- router_pkg holds:
  - ROUTER_WIDTH = 8.
  - ROUTER_FIFO_DEPTH = 16.
  - LEN_LSB = 2.
  - typedef fifo_word_t as a struct {logic hdr; logic [7:0] data}.
  - a function hdr_len(byte) returning the payload length.
- No sub-module is needed. Pointer, flag and count logic stay flat in router_fifo; the storage array is inferred.

Test Plan:
- After rst, write header 8'h0D with lfd_state=1, then payload 8'hA1,8'hA2,8'hA3, then parity 8'h4F. Read 5 times -> data_out sequence 0D,A1,A2,A3,4F one cycle after each read. pkt_active high from the cycle after the header read and low the cycle after the 4F read.
- Write 16 bytes -> full=1 after the 16th. A 17th write of 8'hFF is dropped. Reading 16 bytes returns only the first 16 values, then empty=1. With ERR_FLAG_EN, ovf_err=1.
- Fill to 15 entries, then assert write_enb and read_enb together for 4 cycles -> occupancy stays 15 and full never asserts. Then at full, a simultaneous read/write -> read succeeds, write dropped, count becomes 15.
- Write 6 bytes, then pulse soft_reset one cycle -> empty=1, pkt_active=0, dout_valid=0. A subsequent read_enb yields no strobe. With ERR_FLAG_EN, udf_err=1.
- Pointer wrap: stream 40 bytes (two headers, 8'h1C and 8'h08, with their payloads) while reading continuously -> byte order preserved across wrap. count reloads to 8 then 3 at each header.
- Read while empty, then write 8'h55 in the same cycle -> no dout_valid that cycle. The next cycle's read returns 8'h55.
